// File: rtl/disp_page_sequencer.sv
// Registered K-way page selector for the seven-segment display bank, with blanking gap on page change.
// Optional DISP_FREEZE_EN adds a freeze input that holds the display and suspends page switching.
module disp_page_sequencer #(
    parameter int K            = 4,
    parameter int M            = 6,
    parameter int N            = 7,
    parameter int BLANK_CYCLES = 3,
    parameter int DWELL        = 50000000,
    parameter int BLANK_LEVEL  = 1,
    localparam int SELW        = $clog2(K)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [K*M*N-1:0]    src_data,
    input  logic [SELW-1:0]     sel,
    input  logic                auto_mode,
`ifdef DISP_FREEZE_EN
    input  logic                freeze,
`endif
    output logic [M*N-1:0]      result,
    output logic [SELW-1:0]     page,
    output logic                switching,
    output logic                page_tick
);

    // state | meaning
    // SHOW  | result tracks the selected page live; new requests are evaluated
    // BLANK | result held blank for BLANK_CYCLES clocks; requests ignored

    localparam int DW = $clog2(DWELL + 1);
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
    localparam logic [BW-1:0]   BLANK_LOAD = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [SELW-1:0] PAGE_LAST  = SELW'(K - 1);
    localparam logic [SELW:0]   NUM_PAGES  = (SELW + 1)'(K);
    localparam logic [M*N-1:0]  BLANK_WORD = {(M*N){BLANK_LEVEL != 0}};

    typedef enum logic {SHOW, BLANK} state_t;

    state_t          state;
    logic [DW-1:0]   dwell;
    logic [BW-1:0]   blank_cnt;
    logic [SELW-1:0] target;
    logic [SELW-1:0] next_page;
    logic            dwell_done;
    logic            hold;
    logic [M*N-1:0]  pages [2**SELW];

    // Unused index slots (K not a power of two) are padded so pages[] never reads past src_data.
    for (genvar p = 0; p < 2**SELW; p++) begin : g_page
        if (p < K) begin : g_src
            assign pages[p] = src_data[p*M*N +: M*N];
        end else begin : g_pad
            assign pages[p] = BLANK_WORD;
        end
    end

`ifdef DISP_FREEZE_EN
    assign hold = freeze;
`else
    assign hold = 1'b0;
`endif

    assign next_page  = (page == PAGE_LAST) ? '0 : page + 1'b1;
    assign dwell_done = (dwell == DWELL_LAST);

    always_comb begin
        target = page;
        if (auto_mode) begin
            if (dwell_done) target = next_page;
        end else if ({1'b0, sel} < NUM_PAGES) begin
            target = sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SHOW;
            page      <= '0;
            result    <= BLANK_WORD;
            switching <= 1'b0;
            page_tick <= 1'b0;
            dwell     <= '0;
            blank_cnt <= '0;
        end else begin
            page_tick <= 1'b0;
            case (state)
                SHOW: begin
                    if (!hold) begin
                        // Manual mode keeps the dwell count at zero so auto mode always starts fresh.
                        if (!auto_mode || dwell_done) dwell <= '0;
                        else                          dwell <= dwell + 1'b1;
                        if (target != page) begin
                            page <= target;
                            if (BLANK_CYCLES > 0) begin
                                state     <= BLANK;
                                blank_cnt <= BLANK_LOAD;
                                result    <= BLANK_WORD;
                                switching <= 1'b1;
                            end else begin
                                result    <= pages[target];
                                page_tick <= 1'b1;
                            end
                        end else begin
                            result <= pages[page];
                        end
                    end
                end
                BLANK: begin
                    if (blank_cnt == '0) begin
                        state     <= SHOW;
                        result    <= pages[page];
                        page_tick <= 1'b1;
                        switching <= 1'b0;
                    end else begin
                        blank_cnt <= blank_cnt - 1'b1;
                    end
                end
                default: state <= SHOW;
            endcase
        end
    end

endmodule

// File: tb/tb_disp_page_sequencer.sv
// Bench for disp_page_sequencer: three instances (blanking gap, zero gap, K=3) checked against a
// cycle-level reference model plus directed checks of the documented scenarios.
module tb_disp_page_sequencer;

    localparam int M = 6, N = 7, W = M*N, DWELL = 10;
    localparam int KA = 4, KC = 3;
    localparam logic [W-1:0] ALL_ONES = '1;
    localparam logic [W-1:0] P0 = 42'h123_4567_89AB;
    localparam logic [W-1:0] P1 = 42'h0F0_F0F0_F0F0;
    localparam logic [W-1:0] P2 = 42'h2AA_AAAA_AAAA;
    localparam logic [W-1:0] P3 = 42'h3C3_C3C3_C3C3;
    localparam logic [W-1:0] C0 = 42'h111_2222_3333;
    localparam logic [W-1:0] C1 = 42'h044_4555_5666;
    localparam logic [W-1:0] C2 = 42'h377_7888_8999;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [KA*W-1:0] src;
    logic [1:0]      sel;
    logic            auto_mode;
    logic            freeze = 1'b0;
    logic [W-1:0]    res_a, res_b, res_c;
    logic [1:0]      page_a, page_b, page_c;
    logic            sw_a, sw_b, sw_c, tick_a, tick_b, tick_c;
    logic [KC*W-1:0] src_c;
    logic [1:0]      sel_c;
    logic            auto_c = 1'b0;

    disp_page_sequencer #(.K(KA), .M(M), .N(N), .BLANK_CYCLES(3), .DWELL(DWELL), .BLANK_LEVEL(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .src_data(src), .sel(sel), .auto_mode(auto_mode),
`ifdef DISP_FREEZE_EN
        .freeze(freeze),
`endif
        .result(res_a), .page(page_a), .switching(sw_a), .page_tick(tick_a));

    disp_page_sequencer #(.K(KA), .M(M), .N(N), .BLANK_CYCLES(0), .DWELL(DWELL), .BLANK_LEVEL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .src_data(src), .sel(sel), .auto_mode(auto_mode),
`ifdef DISP_FREEZE_EN
        .freeze(freeze),
`endif
        .result(res_b), .page(page_b), .switching(sw_b), .page_tick(tick_b));

    disp_page_sequencer #(.K(KC), .M(M), .N(N), .BLANK_CYCLES(2), .DWELL(7), .BLANK_LEVEL(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .src_data(src_c), .sel(sel_c), .auto_mode(auto_c),
`ifdef DISP_FREEZE_EN
        .freeze(freeze),
`endif
        .result(res_c), .page(page_c), .switching(sw_c), .page_tick(tick_c));

    int n_asrt = 0;
    int n_fail = 0;
    int ticks_a, ticks_b;

    // Reference model, index 0 = 3-clock gap, index 1 = no gap.
    int           bc [2] = '{3, 0};
    int           m_pg [2], m_blk [2], m_dw [2];
    logic [W-1:0] m_res [2];
    logic         m_tick [2], m_sw [2];

    function automatic logic [W-1:0] slice(input logic [KA*W-1:0] d, input int p);
        return d[p*W +: W];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pg[i] = 0; m_blk[i] = 0; m_dw[i] = 0;
            m_res[i] = ALL_ONES; m_tick[i] = 1'b0; m_sw[i] = 1'b0;
        end
    endtask

    // m_blk counts blank frames still to be shown; m_dw counts clocks spent on the page in auto mode.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int want;
            m_tick[i] = 1'b0;
            if (m_blk[i] > 0) begin
                m_blk[i]--;
                if (m_blk[i] == 0) begin
                    m_res[i] = slice(src, m_pg[i]); m_tick[i] = 1'b1; m_sw[i] = 1'b0;
                end else begin
                    m_res[i] = ALL_ONES;
                end
            end else begin
                want = m_pg[i];
                if (auto_mode) begin
                    if (m_dw[i] == DWELL-1) begin
                        want = (m_pg[i] + 1) % KA; m_dw[i] = 0;
                    end else begin
                        m_dw[i]++;
                    end
                end else begin
                    m_dw[i] = 0;
                    if (int'(sel) < KA) want = int'(sel);
                end
                if (want != m_pg[i]) begin
                    m_pg[i] = want; m_dw[i] = 0;
                    if (bc[i] > 0) begin
                        m_blk[i] = bc[i]; m_res[i] = ALL_ONES; m_sw[i] = 1'b1;
                    end else begin
                        m_res[i] = slice(src, want); m_tick[i] = 1'b1;
                    end
                end else begin
                    m_res[i] = slice(src, m_pg[i]);
                end
            end
        end
    endtask

    task automatic check_all();
        chk("a_result", res_a,  m_res[0]);
        chk("a_page",   page_a, m_pg[0]);
        chk("a_switch", sw_a,   m_sw[0]);
        chk("a_tick",   tick_a, m_tick[0]);
        chk("b_result", res_b,  m_res[1]);
        chk("b_page",   page_b, m_pg[1]);
        chk("b_switch", sw_b,   m_sw[1]);
        chk("b_tick",   tick_b, m_tick[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        if (tick_a) ticks_a++;
        if (tick_b) ticks_b++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [191:0] r;
        src = {P3, P2, P1, P0};
        src_c = {C2, C1, C0};
        sel = 2'd0; sel_c = 2'd0; auto_mode = 1'b0;
        model_reset();

        // reset state and release
        #12;
        chk("rst_result", res_a, ALL_ONES);
        chk("rst_page", page_a, 2'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rel_result", res_a, P0);
        chk("rel_tick", tick_a, 1'b0);
        steps(3);

        // manual switch 0 -> 2 with three blank frames
        sel = 2'd2;
        step();
        chk("b_fast_result", res_b, P2);
        chk("b_fast_switch", sw_b, 1'b0);
        chk("blank1", res_a, ALL_ONES);
        chk("blank1_sw", sw_a, 1'b1);
        step();
        chk("blank2", res_a, ALL_ONES);
        step();
        chk("blank3", res_a, ALL_ONES);
        chk("blank3_sw", sw_a, 1'b1);
        step();
        chk("show2_result", res_a, P2);
        chk("show2_tick", tick_a, 1'b1);
        chk("show2_page", page_a, 2'd2);
        step();
        chk("show2_tick_off", tick_a, 1'b0);

        // no-gap instance: 1 -> 3
        sel = 2'd1;
        steps(5);
        sel = 2'd3;
        step();
        chk("nogap_result", res_b, P3);
        chk("nogap_switch", sw_b, 1'b0);
        steps(4);

        // request during blank: latest wins, page 1 shown for one clock
        sel = 2'd0;
        steps(5);
        sel = 2'd1;
        step();
        chk("req_blank_sw", sw_a, 1'b1);
        sel = 2'd3;
        steps(2);
        step();
        chk("req_p1_result", res_a, P1);
        chk("req_p1_tick", tick_a, 1'b1);
        step();
        chk("req_reblank", res_a, ALL_ONES);
        chk("req_reblank_page", page_a, 2'd3);
        steps(2);
        step();
        chk("req_p3_result", res_a, P3);

        // auto rotation from page 0
        sel = 2'd0;
        steps(6);
        auto_mode = 1'b1;
        ticks_a = 0; ticks_b = 0;
        steps(52);
        chk("auto_ticks_a", ticks_a, 4);
        chk("auto_page_a", page_a, 2'd0);
        chk("auto_ticks_b", ticks_b, 5);
        chk("auto_page_b", page_b, 2'd1);
        auto_mode = 1'b0;
        steps(6);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            src = r[KA*W-1:0];
            if ($urandom_range(5, 0) == 0) sel = 2'($urandom_range(3, 0));
            if ($urandom_range(39, 0) == 0) auto_mode = ~auto_mode;
            step();
        end

        // asynchronous reset in the middle of a blank gap
        auto_mode = 1'b0; sel = 2'd0;
        src = {P3, P2, P1, P0};
        steps(8);
        sel = 2'd2;
        step();
        chk("pre_rst_sw", sw_a, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_result", res_a, ALL_ONES);
        chk("async_page", page_a, 2'd0);
        chk("async_switch", sw_a, 1'b0);
        model_reset();
        sel = 2'd0;
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        steps(3);

        // K=3: out-of-range select ignored
        sel_c = 2'd3;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("c_oor_page", page_c, 2'd0);
            chk("c_oor_sw", sw_c, 1'b0);
        end
        chk("c_oor_result", res_c, C0);
        sel_c = 2'd2;
        steps(3);
        chk("c_sel2_page", page_c, 2'd2);
        chk("c_sel2_result", res_c, C2);
        chk("c_sel2_tick", tick_c, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
